segre_mem_responder: RTL

- Main-memory side of the cache/memory request protocol, sitting behind the icache/dcache arbiter.
- Accepts cache_mem_req_t line requests (cache_id, rd, wr, addr, cache_line) into an in-order request FIFO.
- Models a fixed access latency, performs full-line reads and writes on an internal line array, and returns one response per request, tagged with the originating cache_id.

---
 rtl/segre_mem_responder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/segre_mem_responder.sv
// segre_mem_responder: main-memory side of the cache/memory request protocol.
// Requests are queued in order, each access waits a fixed latency, then a
// full-line read or write is done on the line array and one tagged response
// is returned and held until the consumer accepts it.
module segre_mem_responder #(
    parameter int MEM_LATENCY    = 5,
    parameter int REQ_FIFO_DEPTH = 4,
    parameter int MEM_LINES      = 1024
) (
    input  logic         clk_i,
    input  logic         rsn_i,
    input  logic         req_valid_i,
    input  logic [162:0] req_i,
    output logic         req_ready_o,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic         rsp_cache_id_o,
    output logic         rsp_is_wr_o,
    output logic [31:0]  rsp_addr_o,
    output logic [127:0] rsp_line_o
);

    localparam int ADDR_SIZE   = 32;
    localparam int LINE_BITS   = 128;
    localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
    localparam int IDX_BITS    = $clog2(MEM_LINES);
    localparam int PTR_BITS    = $clog2(REQ_FIFO_DEPTH);
    localparam int CNT_BITS    = $clog2(REQ_FIFO_DEPTH + 1);
    localparam logic [7:0]          LAT_INIT = 8'(MEM_LATENCY - 1);
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(REQ_FIFO_DEPTH);

    // Queued request: only what the response and the array access need.
    typedef struct packed {
        logic                 cache_id;
        logic                 is_wr;
        logic [ADDR_SIZE-1:0] addr;
        logic [LINE_BITS-1:0] line;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Request payload layout: {cache_id, rd, wr, addr, cache_line}.
    logic                 req_cache_id;
    logic                 req_rd;
    logic                 req_wr;
    logic [ADDR_SIZE-1:0] req_addr;
    logic [LINE_BITS-1:0] req_line;

    assign req_cache_id = req_i[162];
    assign req_rd       = req_i[161];
    assign req_wr       = req_i[160];
    assign req_addr     = req_i[159:128];
    assign req_line     = req_i[127:0];

    logic                ready_en;
    logic [CNT_BITS-1:0] count;
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    entry_t              fifo_mem [REQ_FIFO_DEPTH];
    entry_t              act;
    state_t              state;
    logic [7:0]          cnt;
    logic [LINE_BITS-1:0] mem [MEM_LINES];

    logic                push;
    logic                enq;
    logic                pop;
    logic                access_done;
    logic [IDX_BITS-1:0] act_idx;

    // Ready is held low during reset and until the first clock after it.
    assign req_ready_o = ready_en && (count != FULL_CNT);
    assign push        = req_valid_i && req_ready_o;
    // A request that neither reads nor writes completes its handshake only.
    assign enq         = push && (req_rd || req_wr);
    assign pop         = (state == IDLE) && (count != '0);
    assign access_done = (state == WAIT) && (cnt == 8'd0);
    // Offset bits dropped, upper bits ignored: addresses alias modulo MEM_LINES.
    assign act_idx     = act.addr[OFFSET_BITS +: IDX_BITS];

    // FIFO pointers, occupancy and the post-reset ready enable.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            ready_en <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            ready_en <= 1'b1;
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (enq && !pop)
                count <= count + 1'b1;
            else if (!enq && pop)
                count <= count - 1'b1;
        end
    end

    // FIFO storage; write-as-write takes priority over rd when both are set.
    always_ff @(posedge clk_i) begin
        if (enq)
            fifo_mem[wr_ptr] <= {req_cache_id, req_wr, req_addr, req_line};
    end

    // Active request register, loaded when the FSM pops the FIFO head.
    always_ff @(posedge clk_i) begin
        if (pop)
            act <= fifo_mem[rd_ptr];
    end

    // Line array write at the end of the latency window; never reset.
    always_ff @(posedge clk_i) begin
        if (access_done && act.is_wr)
            mem[act_idx] <= act.line;
    end

    // Access FSM with registered response outputs held until accepted.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            rsp_valid_o    <= 1'b0;
            rsp_cache_id_o <= 1'b0;
            rsp_is_wr_o    <= 1'b0;
            rsp_addr_o     <= '0;
            rsp_line_o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state <= WAIT;
                        cnt   <= LAT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state          <= RESP;
                        rsp_valid_o    <= 1'b1;
                        rsp_cache_id_o <= act.cache_id;
                        rsp_is_wr_o    <= act.is_wr;
                        rsp_addr_o     <= act.addr;
                        // A write echoes the line it stores.
                        rsp_line_o     <= act.is_wr ? act.line : mem[act_idx];
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    rsp_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
